// File: rtl/subtractor_pkg.sv
// Shared types and helpers for the chunked subtractor.
package subtractor_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_e;

  // Index counter width. It is never narrower than one bit, so NCHUNK == 1 still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational slice subtractor: {bout, d} = x - y - bin in CHUNK+1-bit math.
module sub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  // If the difference goes negative, the extra top bit becomes 1 and acts as the borrow.
  assign {bout, d} = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/subtractor_2_inputs_seq.sv
// Multi-cycle unsigned subtractor, CHUNK bits per cycle LSB first, valid/ready both sides.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one slice subtracted per cycle
// DONE  | result presented, held until out_ready
module subtractor_2_inputs_seq
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("subtractor_2_inputs_seq: WIDTH must be a multiple of CHUNK");
  end

  sub_state_e       state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx;
  logic             borrow;
  logic [CHUNK-1:0] a_s, b_s, d;
  logic             bw;
  logic             accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);
  assign a_s    = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_s    = b_q[int'(idx)*CHUNK +: CHUNK];

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_s),
    .y    (b_s),
    .bin  (borrow),
    .d    (d),
    .bout (bw)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      borrow     <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        idx    <= '0;
        borrow <= 1'b0;
      end else if (state == BUSY) begin
        result[int'(idx)*CHUNK +: CHUNK] <= d;
        borrow <= bw;
        idx    <= idx + 1'b1;
        if (last) borrow_out <= bw;
      end
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  // On the final slice, d's top bit is the result MSB that is being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == BUSY && last) begin
      overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d[CHUNK-1] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_subtractor_2_inputs_seq.sv
// Scoreboard bench for subtractor_2_inputs_seq (WIDTH=4, CHUNK=2): directed vectors,
// backpressure hold, reset mid-operation, throughput and a short random run.
module tb_subtractor_2_inputs_seq;

  localparam int W = 4;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         borrow_out;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic         overflow;
`endif

  subtractor_2_inputs_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         bw;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_valid = 1'b0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency is checked when out_valid rises, and the response is popped on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          check("latency", cyc - acc_q.pop_front(), N);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", int'(result), int'(e.res));
          check("borrow_out", int'(borrow_out), int'(e.bw));
`ifdef SUB_OVERFLOW_FLAG_EN
          check("overflow", int'(overflow), int'(e.ovf));
`endif
        end
      end
      prev_valid = out_valid;
    end
  end

  // Present one operand pair and push the expected response once it has been accepted.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input exp_t e,
                       input bit wait_done);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) check("result_timeout", 0, 1);
    end
  endtask

  // Directed vectors. The expected values were worked out by hand: result, borrow, signed overflow.
  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    exp_t         e;
  } vec_t;

  vec_t vecs[10] = '{
    '{4'd9,  4'd3,  '{4'h6, 1'b0, 1'b1}},
    '{4'd3,  4'd9,  '{4'hA, 1'b1, 1'b1}},
    '{4'd0,  4'd1,  '{4'hF, 1'b1, 1'b0}},
    '{4'd15, 4'd15, '{4'h0, 1'b0, 1'b0}},
    '{4'd8,  4'd1,  '{4'h7, 1'b0, 1'b1}},
    '{4'd5,  4'd2,  '{4'h3, 1'b0, 1'b0}},
    '{4'd7,  4'd8,  '{4'hF, 1'b1, 1'b1}},
    '{4'd0,  4'd0,  '{4'h0, 1'b0, 1'b0}},
    '{4'd12, 4'd5,  '{4'h7, 1'b0, 1'b1}},
    '{4'd6,  4'd7,  '{4'hF, 1'b1, 1'b0}}
  };

  initial begin
    int first_acc;
    int n;
    exp_t e;

    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_borrow", int'(borrow_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i].va, vecs[i].vb, vecs[i].e, 1'b1);

    // Backpressure: DONE is held for 5 cycles, and in_valid during the hold must be ignored.
    out_ready = 1'b0;
    issue(4'd3, 4'd9, '{4'hA, 1'b1, 1'b1}, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_done", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = 4'd1;
      b = 4'd1;
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_result", int'(result), 10);
      check("hold_borrow", int'(borrow_out), 1);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(4'd10, 4'd4, '{4'h6, 1'b0, 1'b1}, 1'b1);

    // Reset in the middle of BUSY: the operation is dropped and must never produce out_valid.
    issue(4'd9, 4'd3, '{4'h6, 1'b0, 1'b1}, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_borrow", int'(borrow_out), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_no_out_valid", n, 0);

    // Throughput with out_ready held high: one accept every N+2 cycles.
    issue(4'd2, 4'd1, '{4'h1, 1'b0, 1'b0}, 1'b0);
    first_acc = last_acc;
    issue(4'd1, 4'd2, '{4'hF, 1'b1, 1'b0}, 1'b1);
    check("throughput", last_acc - first_acc, N + 2);

    for (int k = 0; k < 200; k++) begin
      logic [W-1:0] ra, rb, rr;
      ra = W'($urandom);
      rb = W'($urandom);
      rr = ra - rb;
      e.res = rr;
      e.bw  = (ra < rb);
      e.ovf = (ra[W-1] != rb[W-1]) && (rr[W-1] != ra[W-1]);
      issue(ra, rb, e, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
